// File: rtl/seg7_capture.sv
// Multiplexed 7-segment bus snooper: recovers debounced BCD per digit and flags illegal glyphs.
// Define SEG7_ALT_GLYPH_EN to accept the alternate 6/7/9 glyph shapes as legal.
module seg7_capture #(
  parameter int NUM_DIGITS   = 6,
  parameter int SETTLE_CYC   = 4,
  parameter int STABLE_SCANS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   update,
  output logic [NUM_DIGITS-1:0]   err
);

  localparam int SCW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int CNW = (STABLE_SCANS < 1) ? 1 : $clog2(STABLE_SCANS + 1);
  localparam logic [SCW-1:0] SC_MAX  = SCW'(SETTLE_CYC);
  localparam logic [CNW-1:0] CNT_MAX = CNW'(STABLE_SCANS);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [NUM_DIGITS-1:0]   sel_q, sel_q_nxt;
  logic [SCW-1:0]          sc, sc_nxt;
  logic                    sel_ok;
  logic                    sample;
  logic [4:0]              dec;
  logic                    legal;
  logic [3:0]              code;

  // Returns {legal, bcd}
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 5'h10;
      7'b0110000: decode = 5'h11;
      7'b1101101: decode = 5'h12;
      7'b1111001: decode = 5'h13;
      7'b0110011: decode = 5'h14;
      7'b1011011: decode = 5'h15;
      7'b1011111: decode = 5'h16;
      7'b1110000: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1111011: decode = 5'h19;
`ifdef SEG7_ALT_GLYPH_EN
      7'b0011111: decode = 5'h16;
      7'b1110010: decode = 5'h17;
      7'b1110011: decode = 5'h19;
`endif
      default:    decode = 5'h00;
    endcase
  endfunction

  assign dec    = decode(seg_in);
  assign legal  = dec[4];
  assign code   = dec[3:0];
  assign sel_ok = $onehot(dig_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel_q <= '0;
      sc    <= '0;
    end else begin
      state <= state_nxt;
      sel_q <= sel_q_nxt;
      sc    <= sc_nxt;
    end
  end

  // A single sample is taken once the select has held steady for SETTLE_CYC+1 edges
  always_comb begin
    state_nxt = state;
    sel_q_nxt = sel_q;
    sc_nxt    = sc;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_ok) begin
          state_nxt = SETTLE;
          sel_q_nxt = dig_sel;
          sc_nxt    = SCW'(1);
        end
      end
      SETTLE: begin
        if (!sel_ok) begin
          state_nxt = IDLE;
        end else if (dig_sel != sel_q) begin
          sel_q_nxt = dig_sel;
          sc_nxt    = SCW'(1);
        end else if (sc == SC_MAX) begin
          sample    = 1'b1;
          state_nxt = HOLD;
        end else begin
          sc_nxt = sc + SCW'(1);
        end
      end
      HOLD: begin
        if (!sel_ok) begin
          state_nxt = IDLE;
        end else if (dig_sel != sel_q) begin
          state_nxt = SETTLE;
          sel_q_nxt = dig_sel;
          sc_nxt    = SCW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [3:0]     cand;
    logic [3:0]     bcd_q;
    logic [CNW-1:0] cnt;
    logic [CNW-1:0] cnt_new;
    logic           valid_q;
    logic           upd_q;
    logic           err_q;
    logic           hit;
    logic           commit;

    assign hit = sample & sel_q[i];

    always_comb begin
      cnt_new = CNW'(1);
      if (code == cand) begin
        cnt_new = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNW'(1);
      end
    end

    // Re-committing an unchanged saturated value must not pulse update
    assign commit = hit & legal & (cnt_new == CNT_MAX) & (~valid_q | (code != bcd_q));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cand    <= '0;
        cnt     <= '0;
        bcd_q   <= '0;
        valid_q <= 1'b0;
        upd_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        upd_q <= commit;
        if (hit && legal) begin
          cand <= code;
          cnt  <= cnt_new;
        end else if (hit) begin
          cnt <= '0;
        end
        if (commit) begin
          bcd_q   <= code;
          valid_q <= 1'b1;
        end
        if (hit && !legal) begin
          err_q <= 1'b1;
        end else if (err_clr) begin
          err_q <= 1'b0;
        end
      end
    end

    assign bcd_out[4*i +: 4] = bcd_q;
    assign digit_valid[i]    = valid_q;
    assign update[i]         = upd_q;
    assign err[i]            = err_q;
  end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Reverse path of the clock's BCD-to-seven-segment display drive: snoops a multiplexed 7-segment bus (segment lines plus one-hot digit select) and recovers debounced BCD digits.
- Used in the real-time clock for display readback/self-check: compares what is shown against the timekeeping registers, and flags illegal glyphs.
- One settle-then-sample FSM is shared by all digits. Each digit has its own stability filter and committed output register.

Parameters:
NUM_DIGITS, 6, number of multiplexed digits (hh:mm:ss); must be >= 1
SETTLE_CYC, 4, clock cycles dig_sel must hold the same one-hot value before seg_in is sampled; must be >= 1
STABLE_SCANS, 3, consecutive identical valid samples of a digit required before commit; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
seg_in  input  7  segment lines, active high, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
dig_sel  input  NUM_DIGITS  one-hot digit enable; bit i = digit i
err_clr  input  1  clears all err bits
bcd_out  output  4*NUM_DIGITS  committed BCD; digit i at bits [4i+3:4i]
digit_valid  output  NUM_DIGITS  digit i has been committed at least once since reset
update  output  NUM_DIGITS  one-cycle pulse: digit i committed a new value
err  output  NUM_DIGITS  sticky: digit i sampled an illegal pattern

Behaviour:
- Reset (async assert, sync release): every output is 0, every cand/cnt is 0, FSM is in IDLE.
- Legal glyph table (seg_in -> BCD):
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4
  - 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9
  - Any other value is illegal.
- sel_ok means dig_sel has exactly one bit set. Zero bits or two or more bits are not sel_ok.
- FSM states: IDLE, SETTLE, HOLD. Internal registers: sel_q (last dig_sel) and settle counter sc.
  - IDLE: when sel_ok, go to SETTLE, sel_q=dig_sel, sc=1.
  - SETTLE:
    - If !sel_ok, go to IDLE.
    - Else if dig_sel!=sel_q, restart: sel_q=dig_sel, sc=1.
    - Else if sc==SETTLE_CYC, take the sample on this edge and go to HOLD.
    - Else sc=sc+1.
  - HOLD: at most one sample per selection.
    - If !sel_ok, go to IDLE.
    - Else if dig_sel!=sel_q, go to SETTLE with sc=1 for the new digit.
    - Otherwise stay in HOLD.
- Sample timing: seg_in is sampled on the (SETTLE_CYC+1)th consecutive rising edge at which dig_sel holds the same one-hot value.
  - All register effects of the sample happen on that edge and are visible the next cycle.
  - A select change at any point before the sample aborts that sample with no side effects.
- Sample of digit i, legal code c:
  - If c==cand[i], cnt[i]=min(cnt[i]+1, STABLE_SCANS).
  - Else cand[i]=c, cnt[i]=1.
  - Commit when the new cnt[i]==STABLE_SCANS and (digit_valid[i]==0 or c!=bcd_out digit i). Commit does:
    - write bcd_out digit i = c
    - set digit_valid[i]
    - update[i]=1 for exactly one cycle
  - A saturated repeat of an already committed value does not pulse update.
- Sample of digit i, illegal pattern: err[i]=1, cnt[i]=0, cand[i] unchanged. bcd_out, digit_valid and update are unaffected.
- err_clr clears all err bits. If err_clr and a new error arrive on the same edge, set wins for that digit.
- update is 0 in every cycle without a commit. At most one update bit is high in any cycle.
- Reset asserted mid-settle or mid-filter returns everything to reset values immediately.

Optional Feature:
Macro: SEG7_ALT_GLYPH_EN
- Defined: these alternate glyphs are also legal and decode normally:
  - 0011111=6 (no tail a)
  - 1110010=7 (with f)
  - 1110011=9 (no tail d)
- Not defined: those three patterns are illegal and set err.

Test Plan:
- Default params; dig_sel=000001 held 5 edges with seg_in=1101101, repeated 3 separate selections -> update[0] pulses once after the 3rd sample; bcd_out[3:0]=2; digit_valid[0]=1.
- dig_sel changes from 000001 to 000010 after 3 edges -> no sample for digit 0; digit 1 settles and samples on its 5th edge.
- seg_in=0000001 sampled on digit 2 -> err[2]=1; bcd_out unchanged; err_clr pulse -> err=0; error and err_clr on the same edge -> err[2] stays 1.
- Digit 0 committed at 2; then samples 3,3,2,3,3,3 -> only the final 3 commits, with one update pulse; bcd_out[3:0]=3.
- dig_sel=000011 or 000000 during SETTLE -> no sample, FSM in IDLE; rst_n low mid-settle -> all outputs 0 asynchronously.
- seg_in=0011111: with SEG7_ALT_GLYPH_EN it decodes to 6; without it err sets.
